// File: rtl/ld_ud_counter.sv
// Loadable up/down binary counter with count enable, combinational terminal
// count (tc) and a registered carry/borrow flag (co) that records a wrap.
module ld_ud_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             co
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             co_q, co_d;
   logic [WIDTH:0]   step_sum;
   logic             step_carry;

   // One WIDTH-bit adder/subtractor; its extra MSB is the carry (up) or the
   // borrow (down, 0 - 1 sets the top bit), which is the source of co.
   always_comb begin
      step_sum = '0;
      if (up) begin
         step_sum = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         step_sum = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
      end
      step_carry = step_sum[WIDTH];
   end

   always_comb begin
      q_d  = q_q;
      co_d = 1'b0;
      if (load) begin
         q_d = d_in;
      end else if (en) begin
         q_d  = step_sum[WIDTH-1:0];
         co_d = step_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q  <= '0;
         co_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         co_q <= co_d;
      end
   end

   assign q  = q_q;
   assign co = co_q;
   assign tc = en & ~load & (up ? (q_q == '1) : (q_q == '0));

endmodule

// File: tb/tb_ld_ud_counter.sv
// Checks a WIDTH=4 and a WIDTH=8 counter, driven from shared controls, against
// an arithmetic model every cycle, plus literal checks of the directed sequences.
module tb_ld_ud_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
   logic [7:0] d8 = '0;
   logic [3:0] d4;
   logic [3:0] q4;
   logic [7:0] q8;
   logic       tc4, co4, tc8, co8;

   int unsigned checks = 0;
   int unsigned errors = 0;

   assign d4 = d8[3:0];

   always #5 clk = ~clk;

   ld_ud_counter #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .load(load), .en(en), .up(up),
      .d_in(d4), .q(q4), .tc(tc4), .co(co4)
   );

   ld_ud_counter #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .load(load), .en(en), .up(up),
      .d_in(d8), .q(q8), .tc(tc8), .co(co8)
   );

   // Reference model: plain modular arithmetic per edge.
   int  m4_q = 0, m4_co = 0, m8_q = 0, m8_co = 0;
   bit  valid = 1'b0;

   task automatic model_step(input int w, input int d, inout int mq, inout int mco);
      int modv;
      modv = 1 << w;
      if (reset) begin
         mq = 0; mco = 0;
      end else if (load) begin
         mq = d % modv; mco = 0;
      end else if (en) begin
         if (up) begin
            mco = (mq == modv - 1) ? 1 : 0;
            mq  = (mq + 1) % modv;
         end else begin
            mco = (mq == 0) ? 1 : 0;
            mq  = (mq + modv - 1) % modv;
         end
      end else begin
         mco = 0;
      end
   endtask

   always @(posedge clk) begin
      model_step(4, int'(d4), m4_q, m4_co);
      model_step(8, int'(d8), m8_q, m8_co);
      if (reset) valid = 1'b1;
   end

   function automatic int exp_tc(input int w, input int mq);
      if (!en || load) return 0;
      if (up) return (mq == (1 << w) - 1) ? 1 : 0;
      return (mq == 0) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, plus the co(n+1) == tc(n) relation.
   int prev_tc4 = 0, prev_tc8 = 0;
   bit prev_rst = 1'b1, prev_valid = 1'b0;
   always @(negedge clk) begin
      if (valid) begin
         chk("model q4", int'(q4), m4_q);
         chk("model co4", int'(co4), m4_co);
         chk("model tc4", int'(tc4), exp_tc(4, m4_q));
         chk("model q8", int'(q8), m8_q);
         chk("model co8", int'(co8), m8_co);
         chk("model tc8", int'(tc8), exp_tc(8, m8_q));
         if (prev_valid && !prev_rst) begin
            chk("co4 follows tc4", int'(co4), prev_tc4);
            chk("co8 follows tc8", int'(co8), prev_tc8);
         end
      end
      prev_tc4   = int'(tc4);
      prev_tc8   = int'(tc8);
      prev_rst   = reset;
      prev_valid = valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int eq, input int etc, input int eco);
      chk({name, " q"}, int'(q4), eq);
      chk({name, " tc"}, int'(tc4), etc);
      chk({name, " co"}, int'(co4), eco);
   endtask

   initial begin
      // 1) reset wins over load and en
      reset = 1; load = 1; d8 = 8'h0A; en = 1; up = 1;
      tick(); tick();
      lit("reset", 0, 0, 0);
      chk("reset q8", int'(q8), 0);

      // 2) load D, count up through the wrap
      reset = 0; load = 1; d8 = 8'h0D; en = 0;
      tick(); lit("load D", 13, 0, 0);
      load = 0; en = 1; up = 1;
      tick(); lit("up E", 14, 0, 0);
      tick(); lit("up F", 15, 1, 0);
      tick(); lit("up wrap", 0, 0, 1);
      en = 0;
      tick(); lit("up hold", 0, 0, 0);

      // 3) load 1, count down through the wrap
      load = 1; d8 = 8'h01;
      tick(); lit("load 1", 1, 0, 0);
      load = 0; en = 1; up = 0;
      tick(); lit("down 0", 0, 1, 0);
      tick(); lit("down wrap", 15, 0, 1);
      tick(); lit("down E", 14, 0, 0);

      // 4) hold, then load beats count
      load = 1; d8 = 8'h05; en = 0;
      tick();
      load = 0;
      for (int i = 0; i < 4; i++) begin
         tick(); lit("hold 5", 5, 0, 0);
      end
      load = 1; en = 1; up = 1; d8 = 8'h09;
      tick(); lit("load beats en", 9, 0, 0);

      // 5) reset mid-count, then resume
      load = 1; d8 = 8'h06; en = 0;
      tick();
      load = 0; en = 1; up = 1;
      tick(); lit("count 7", 7, 0, 0);
      reset = 1;
      tick(); chk("mid reset q", int'(q4), 0);
      reset = 0;
      tick(); lit("after reset", 1, 0, 0);

      // 6) random traffic; the compare process checks every cycle
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         load  = ($urandom_range(0, 9) == 0);
         en    = ($urandom_range(0, 9) < 8);
         up    = ($urandom_range(0, 3) != 0) ? up : ~up;
         d8    = ($urandom_range(0, 3) == 0) ? 8'hFF :
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tick();
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
